// File: rtl/core_pkg.sv
// Shared core definitions: ISA opcodes, bubble encoding and fetch-sequencer states.
package core_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_NOP  = 2'b10;
  localparam logic [1:0] OP_JUMP = 2'b11;

  localparam logic [7:0] NOP_CODE = 8'b1000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_predecode.sv
// Combinational pre-decode of a fetched instruction: flags jumps and forms the
// PC-relative target (6-bit signed offset, wraps modulo 2^PC_W).
module fetch_predecode
  import core_pkg::*;
#(
  parameter int PC_W    = core_pkg::PC_W,
  parameter int INSTR_W = core_pkg::INSTR_W
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [PC_W-1:0]    pc,
  output logic               is_jump,
  output logic [PC_W-1:0]    jump_target
);

  logic [PC_W-1:0] offset;

  assign is_jump     = (instr[7:6] == OP_JUMP);
  assign offset      = {{(PC_W-6){instr[5]}}, instr[5:0]};
  assign jump_target = pc + offset;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, resolves jumps in fetch, handles stall,
// redirect and end-of-program halt, and loads the IF/ID register.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int                  PC_W      = core_pkg::PC_W,
  parameter int                  INSTR_W   = core_pkg::INSTR_W,
  parameter int unsigned         MEM_DEPTH = 8,
  parameter logic [INSTR_W-1:0]  NOP_CODE  = core_pkg::NOP_CODE
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instruction_Code,
  output logic [PC_W-1:0]    PC,
  input  logic               Stall,
  input  logic               Redirect_Valid,
  input  logic [PC_W-1:0]    Redirect_PC,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [PC_W-1:0]    IF_ID_PC,
  output logic               IF_ID_Valid,
  output logic               Halted,
  output logic [7:0]         Fetch_Count
);

  fetch_state_t       state, state_nxt;
  logic [PC_W-1:0]    pc_nxt;
  logic [INSTR_W-1:0] instr_nxt;
  logic [PC_W-1:0]    ipc_nxt;
  logic               valid_nxt;
  logic [7:0]         count_nxt;
  logic               is_jump;
  logic [PC_W-1:0]    jump_target;
  logic               at_end;

  fetch_predecode #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_predecode (
    .instr       (Instruction_Code),
    .pc          (PC),
    .is_jump     (is_jump),
    .jump_target (jump_target)
  );

  assign at_end = (32'(PC) >= MEM_DEPTH);
  assign Halted = (state == HALT);

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state       <= RUN;
      PC          <= '0;
      IF_ID_Instr <= NOP_CODE;
      IF_ID_PC    <= '0;
      IF_ID_Valid <= 1'b0;
      Fetch_Count <= 8'd0;
    end else begin
      state       <= state_nxt;
      PC          <= pc_nxt;
      IF_ID_Instr <= instr_nxt;
      IF_ID_PC    <= ipc_nxt;
      IF_ID_Valid <= valid_nxt;
      Fetch_Count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    instr_nxt = IF_ID_Instr;
    ipc_nxt   = IF_ID_PC;
    valid_nxt = IF_ID_Valid;
    count_nxt = Fetch_Count;

    // Redirect is the only way out of HALT and beats a concurrent stall.
    if (Redirect_Valid) begin
      state_nxt = RUN;
      pc_nxt    = Redirect_PC;
      instr_nxt = NOP_CODE;
      valid_nxt = 1'b0;
    end else if (state == RUN && !Stall) begin
      if (at_end) begin
        state_nxt = HALT;
        instr_nxt = NOP_CODE;
        valid_nxt = 1'b0;
      end else if (is_jump) begin
        pc_nxt    = jump_target;
        instr_nxt = NOP_CODE;
        valid_nxt = 1'b0;
      end else begin
        instr_nxt = Instruction_Code;
        ipc_nxt   = PC;
        valid_nxt = 1'b1;
        pc_nxt    = PC + PC_W'(1);
        if (Fetch_Count != 8'hFF) count_nxt = Fetch_Count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed test-plan scenarios plus randomized programs/stalls/redirects checked
// against a behavioural model of the fetch rules.
module tb_fetch_sequencer;
  import core_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] instruction_code;
  logic [7:0] pc;
  logic       stall;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc;
  logic       if_id_valid;
  logic       halted;
  logic [7:0] fetch_count;

  logic [7:0] mem [8];
  int checks = 0;
  int failures = 0;

  int         m_pc, m_ipc, m_cnt;
  logic [7:0] m_instr;
  bit         m_valid, m_halt;

  always #5 clk = ~clk;

  assign instruction_code = (pc < 8'd8) ? mem[pc[2:0]] : 8'h00;

  fetch_sequencer dut (
    .clk              (clk),
    .Reset            (reset_n),
    .Instruction_Code (instruction_code),
    .PC               (pc),
    .Stall            (stall),
    .Redirect_Valid   (redirect_valid),
    .Redirect_PC      (redirect_pc),
    .IF_ID_Instr      (if_id_instr),
    .IF_ID_PC         (if_id_pc),
    .IF_ID_Valid      (if_id_valid),
    .Halted           (halted),
    .Fetch_Count      (fetch_count)
  );

  // Reference model: one clock edge of the fetch rules, priority order as listed.
  task automatic model_edge();
    logic [7:0] ins;
    int off;
    if (!reset_n) begin
      m_pc = 0; m_ipc = 0; m_cnt = 0; m_instr = 8'h80; m_valid = 0; m_halt = 0;
    end else if (redirect_valid) begin
      m_pc = int'(redirect_pc); m_instr = 8'h80; m_valid = 0; m_halt = 0;
    end else if (m_halt || stall) begin
      // everything holds
    end else if (m_pc >= 8) begin
      m_halt = 1; m_instr = 8'h80; m_valid = 0;
    end else begin
      ins = mem[m_pc];
      if (ins[7:6] == 2'b11) begin
        off = int'(ins[5:0]);
        if (off >= 32) off = off - 64;
        m_pc = (m_pc + off + 256) % 256;
        m_instr = 8'h80; m_valid = 0;
      end else begin
        m_instr = ins; m_ipc = m_pc; m_valid = 1;
        m_pc = m_pc + 1;
        if (m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_program(input logic [63:0] p);
    for (int i = 0; i < 8; i++) mem[i] = p[63-8*i -: 8];
  endtask

  task automatic do_reset();
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if (pc !== 8'd0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (if_id_instr !== 8'h80) begin failures++; $display("FAIL reset_instr got=%0h exp=80", if_id_instr); end
    checks++; if (if_id_pc !== 8'd0) begin failures++; $display("FAIL reset_ifpc got=%0h exp=0", if_id_pc); end
    checks++; if (if_id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if_id_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (fetch_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
  endtask

  task automatic test_program();
    int exp_pc [8] = '{0, 1, 2, -1, 5, 6, 7, -1};
    load_program(64'h2D6B6AC225658080);
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (if_id_valid !== (exp_pc[k] >= 0)) begin
        failures++; $display("FAIL prog_valid edge=%0d got=%0b exp=%0b", k, if_id_valid, exp_pc[k] >= 0);
      end
      if (exp_pc[k] >= 0) begin
        checks++;
        if (if_id_pc !== 8'(exp_pc[k]) || if_id_instr !== mem[exp_pc[k]]) begin
          failures++; $display("FAIL prog_ifid edge=%0d got=%0d/%0h exp=%0d/%0h", k, if_id_pc, if_id_instr, exp_pc[k], mem[exp_pc[k]]);
        end
      end
      if (k >= 6) begin
        checks++;
        if (halted !== (k == 7)) begin failures++; $display("FAIL prog_halted edge=%0d got=%0b exp=%0b", k, halted, k == 7); end
      end
    end
    checks++; if (fetch_count !== 8'd6) begin failures++; $display("FAIL prog_count got=%0d exp=6", fetch_count); end
    checks++; if (pc !== 8'd8) begin failures++; $display("FAIL prog_endpc got=%0d exp=8", pc); end
  endtask

  task automatic test_stall();
    int exp_pc [4] = '{1, 2, -1, 5};
    load_program(64'h2D6B6AC225658080);
    do_reset();
    step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (pc !== 8'd1 || if_id_pc !== 8'd0 || if_id_instr !== 8'h2D || !if_id_valid || fetch_count !== 8'd1) begin
        failures++; $display("FAIL stall_hold cyc=%0d got pc=%0d ifpc=%0d instr=%0h v=%0b cnt=%0d exp 1/0/2d/1/1",
                             k, pc, if_id_pc, if_id_instr, if_id_valid, fetch_count);
      end
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (if_id_valid !== (exp_pc[k] >= 0) || (exp_pc[k] >= 0 && if_id_pc !== 8'(exp_pc[k]))) begin
        failures++; $display("FAIL stall_resume cyc=%0d got=%0d v=%0b exp=%0d", k, if_id_pc, if_id_valid, exp_pc[k]);
      end
    end
  endtask

  task automatic test_jump_self();
    load_program(64'h0040C00000000000);
    do_reset();
    step(); step();
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (pc !== 8'd2 || if_id_valid !== 1'b0 || fetch_count !== 8'd2 || if_id_instr !== 8'h80) begin
        failures++; $display("FAIL jself cyc=%0d got pc=%0d v=%0b cnt=%0d instr=%0h exp 2/0/2/80",
                             k, pc, if_id_valid, fetch_count, if_id_instr);
      end
    end
  endtask

  task automatic test_jump_back();
    int exp_pc [6] = '{-1, 1, 2, -1, 1, 2};
    load_program(64'h004142FE00000000);
    do_reset();
    step(); step(); step();
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (if_id_valid !== (exp_pc[k] >= 0) || (exp_pc[k] >= 0 && if_id_pc !== 8'(exp_pc[k]))) begin
        failures++; $display("FAIL jback cyc=%0d got=%0d v=%0b exp=%0d", k, if_id_pc, if_id_valid, exp_pc[k]);
      end
      if (k == 0) begin
        checks++; if (pc !== 8'd1) begin failures++; $display("FAIL jback_target got=%0d exp=1", pc); end
      end
    end
  endtask

  task automatic test_halt_redirect();
    load_program(64'h2D6B6AC225658080);
    do_reset();
    repeat (8) step();
    stall = 1'b1;
    step();
    checks++; if (halted !== 1'b1 || pc !== 8'd8) begin failures++; $display("FAIL halt_hold got h=%0b pc=%0d exp 1/8", halted, pc); end
    redirect_valid = 1'b1; redirect_pc = 8'd4;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++;
    if (halted !== 1'b0 || if_id_valid !== 1'b0 || pc !== 8'd4 || if_id_instr !== 8'h80) begin
      failures++; $display("FAIL redir_bubble got h=%0b v=%0b pc=%0d instr=%0h exp 0/0/4/80", halted, if_id_valid, pc, if_id_instr);
    end
    step();
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 8'd4 || if_id_instr !== 8'h25) begin
      failures++; $display("FAIL redir_deliver got v=%0b pc=%0d instr=%0h exp 1/4/25", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_reset_mid_jump();
    load_program(64'h2D6B6AC225658080);
    do_reset();
    step(); step(); step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (pc !== 8'd0 || if_id_valid !== 1'b0 || fetch_count !== 8'd0 || halted !== 1'b0) begin
      failures++; $display("FAIL mid_reset got pc=%0d v=%0b cnt=%0d h=%0b exp 0/0/0/0", pc, if_id_valid, fetch_count, halted);
    end
  endtask

  task automatic test_saturation();
    load_program(64'h0000FE0000000000);
    do_reset();
    repeat (400) step();
    checks++; if (fetch_count !== 8'd255) begin failures++; $display("FAIL sat_count got=%0d exp=255", fetch_count); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c < 80; c++) begin
        stall          = ($urandom_range(0, 3) == 0);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc    = 8'($urandom_range(0, 10));
        reset_n        = ($urandom_range(0, 49) != 0);
        step();
        checks++; if (pc !== 8'(m_pc)) begin failures++; $display("FAIL rnd_pc it=%0d c=%0d got=%0d exp=%0d", it, c, pc, m_pc); end
        checks++; if (halted !== m_halt) begin failures++; $display("FAIL rnd_halted it=%0d c=%0d got=%0b exp=%0b", it, c, halted, m_halt); end
        checks++; if (if_id_valid !== m_valid) begin failures++; $display("FAIL rnd_valid it=%0d c=%0d got=%0b exp=%0b", it, c, if_id_valid, m_valid); end
        checks++; if (fetch_count !== 8'(m_cnt)) begin failures++; $display("FAIL rnd_count it=%0d c=%0d got=%0d exp=%0d", it, c, fetch_count, m_cnt); end
        checks++; if (if_id_instr !== m_instr) begin failures++; $display("FAIL rnd_instr it=%0d c=%0d got=%0h exp=%0h", it, c, if_id_instr, m_instr); end
        if (m_valid) begin
          checks++; if (if_id_pc !== 8'(m_ipc)) begin failures++; $display("FAIL rnd_ifpc it=%0d c=%0d got=%0d exp=%0d", it, c, if_id_pc, m_ipc); end
        end
      end
      reset_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    test_reset();
    test_program();
    test_stall();
    test_jump_self();
    test_jump_back();
    test_halt_redirect();
    test_reset_mid_jump();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Fetch-stage controller that sequences the 8-entry, 8-bit-instruction memory for the pipelined core. Owns the PC register, drives the memory's combinational read address and pre-decodes each fetched instruction so jumps redirect in the fetch stage. Also handles decode-stage stall, external redirect and end-of-program halt. Loads the IF/ID pipeline register consumed by decode.

## Interface
Parameters:
- PC_W, 8, PC and address width
- INSTR_W, 8, instruction width
- MEM_DEPTH, 8, number of valid instruction-memory words; PC ≥ MEM_DEPTH means end of program
- NOP_CODE, 8'b10000000, instruction injected into bubbles

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  reset, synchronous, active-low
- Instruction_Code  in  INSTR_W  combinational read data from instruction memory at PC
- PC  out  PC_W  fetch address to instruction memory (registered)
- Stall  in  1  decode cannot accept; hold PC and IF/ID
- Redirect_Valid  in  1  external PC override (debug/restart)
- Redirect_PC  in  PC_W  override target
- IF_ID_Instr  out  INSTR_W  registered instruction to decode
- IF_ID_PC  out  PC_W  PC of IF_ID_Instr
- IF_ID_Valid  out  1  IF_ID_Instr is a real instruction
- Halted  out  1  sequencer in HALT
- Fetch_Count  out  8  instructions delivered, saturates at 255

## Operation
- ISA fields: [7:6] opcode (00 mov, 01 addi, 10 nop, 11 jump); jump offset = [5:0], two's complement.
- Jump target = PC + sext(offset), computed modulo 2^PC_W and wrapping.
- States: RUN, HALT.
- RUN, per cycle, first match wins:
  1. Redirect_Valid: PC←Redirect_PC; IF/ID←NOP_CODE, Valid=0.
  2. Stall: PC, IF/ID, Fetch_Count hold.
  3. PC ≥ MEM_DEPTH: →HALT; IF/ID←NOP_CODE, Valid=0; PC holds.
  4. Opcode 11: PC←jump target; IF/ID←NOP_CODE, Valid=0. The jump is consumed in fetch and never reaches decode.
  5. Otherwise: IF/ID←{Instruction_Code, PC}, Valid=1; PC←PC+1; Fetch_Count increments, saturating.
- Fetched nop (opcode 10) is delivered with Valid=1.
- HALT: PC and IF/ID hold, with IF/ID at NOP and Valid=0. Halted=1. Stall is ignored.
  - Exit only through Redirect_Valid, which performs rule 1 and goes to RUN; or through Reset.
- A redirect to PC ≥ MEM_DEPTH re-enters HALT on the following cycle.

## Timing
- Reset (Reset=0 at clock edge) forces:
  - PC=0, IF_ID_Instr=NOP_CODE, IF_ID_PC=0, IF_ID_Valid=0
  - Halted=0, Fetch_Count=0, state=RUN
- Reset has priority over all inputs. A mid-operation reset discards pending jumps and stalls.
- Cycles after reset release:
  - First edge with Reset=1 loads Mem[0] into IF/ID.
  - IF_ID_Valid=1 in the following cycle.
- Latency: PC to IF/ID is 1 cycle. Throughput is 1 instruction/cycle.
- Taken jump costs exactly one bubble cycle. Redirect costs one bubble.
- Redirect and Stall in the same cycle: redirect wins.
- Jump fetched while Stall=1: not taken until Stall drops.
- Halted asserts in the cycle after PC ≥ MEM_DEPTH is seen.
- All outputs are registered. No combinational path from input to output except memory data into IF/ID setup.

## Structure
- Shared package core_pkg:
  - opcode localparams OP_MOV, OP_ADDI, OP_NOP, OP_JUMP
  - NOP_CODE
  - state enum {RUN, HALT}
  - PC_W, INSTR_W
- One sub-module: fetch_predecode. Combinational; takes instruction and PC, produces is_jump and jump target. It is reused by later branch work.
- Instruction memory stays a separate instance; this block only drives its address.

## Test plan
- Program {2D, 6B, 6A, C2, 25, 65, 80, 80}, no stall:
  - IF/ID delivers PCs 0,1,2, bubble, 5,6,7.
  - Halted=1 two cycles after PC 7 is fetched.
  - Fetch_Count=6.
- Stall held 3 cycles while PC=1: IF/ID holds PC 0 contents and PC stays 1. Sequence then resumes unchanged.
- Jump offset 0 (C0) at PC 2: PC stays 2, IF_ID_Valid=0 every cycle, Fetch_Count frozen.
- Jump offset −2 (FE) at PC 3: next PC=1, one bubble, then PCs 1,2,3 loop.
- In HALT, Redirect_Valid with Redirect_PC=4: Halted=0 next cycle, IF/ID bubble, then PC 4 delivered. A simultaneous Stall is ignored.
- Reset=0 asserted mid-jump (C2 fetched at PC 3): next cycle PC=0, IF_ID_Valid=0, Fetch_Count=0.
